// File: rtl/gft_to_gfaes_stream.sv
// ============================================================================
//  Module   : gft_to_gfaes_stream
//  Brief    : Streaming tower-field to AES-basis converter (GF(16)/GF(256)
//             lanes) with an output register plus one skid register.
//             Optional packet framing (o_last) enabled by GFT_STREAM_LAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gft_to_gfaes_stream #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*LANES-1:0]   i_data,
    input  logic                 i_mode,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [15:0]          i_len,
    output logic [8*LANES-1:0]   o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_last
);

    localparam int c_DW = 8 * LANES;

    // Basis change of one byte; in nibble mode both halves are mapped independently.
    function automatic logic [7:0] f_conv(input logic [7:0] a, input logic mode);
        logic [7:0] c;
        if (mode) begin
            c[0] = a[0] ^ a[4] ^ a[5] ^ a[6] ^ a[7];
            c[1] = a[4] ^ a[5] ^ a[6] ^ a[7];
            c[2] = a[1] ^ a[2] ^ a[5] ^ a[7];
            c[3] = a[1] ^ a[2] ^ a[7];
            c[4] = a[1] ^ a[2] ^ a[3] ^ a[4] ^ a[7];
            c[5] = a[1] ^ a[3] ^ a[4] ^ a[5];
            c[6] = a[2] ^ a[4] ^ a[5] ^ a[7];
            c[7] = a[1] ^ a[3] ^ a[4] ^ a[5] ^ a[7];
        end else begin
            c[0] = a[0];
            c[1] = a[1] ^ a[2];
            c[2] = a[1] ^ a[3];
            c[3] = a[3];
            c[4] = a[4];
            c[5] = a[5] ^ a[6];
            c[6] = a[5] ^ a[7];
            c[7] = a[7];
        end
        return c;
    endfunction

    logic [c_DW-1:0] w_conv;
    logic            w_in_last;
    logic            w_accept;
    logic            w_skid_load;
    logic            w_skid_valid_nxt;

    logic [c_DW-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic [c_DW-1:0] r_skid_data;
    logic            r_skid_valid;
    logic            r_skid_last;
    logic            r_in_ready;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_conv[8*g +: 8] = f_conv(i_data[8*g +: 8], i_mode);
        end
    endgenerate

    assign w_accept = i_valid & r_in_ready;

`ifdef GFT_STREAM_LAST_EN
    logic [15:0] r_cnt;
    logic [15:0] r_len;
    logic [15:0] w_len_eff;

    // Length is sampled only on a packet's first word; zero behaves as one.
    assign w_len_eff = (r_cnt == 16'd0) ? ((i_len == 16'd0) ? 16'd1 : i_len) : r_len;
    assign w_in_last = (r_cnt == (w_len_eff - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'd0;
            r_len <= 16'd0;
        end else if (w_accept) begin
            if (r_cnt == 16'd0) begin
                r_len <= w_len_eff;
            end
            r_cnt <= w_in_last ? 16'd0 : (r_cnt + 16'd1);
        end
    end
`else
    logic w_len_unused;
    assign w_len_unused = ^i_len;
    assign w_in_last    = 1'b0;
`endif

    // The skid fills only when a word is accepted while the output is stalled.
    assign w_skid_load      = ~r_skid_valid & w_accept & r_out_valid & ~o_ready;
    assign w_skid_valid_nxt = w_skid_load | (r_skid_valid & ~o_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready   <= ~w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (r_skid_valid) begin
                if (o_ready) begin
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_out_valid <= 1'b1;
                end
            end else if (w_accept) begin
                if (!r_out_valid || o_ready) begin
                    r_out_data  <= w_conv;
                    r_out_last  <= w_in_last;
                    r_out_valid <= 1'b1;
                end else begin
                    r_skid_data <= w_conv;
                    r_skid_last <= w_in_last;
                end
            end else if (o_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign i_ready = r_in_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;
    assign o_last  = r_out_last;

endmodule

`default_nettype wire
